// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline control path:
// the decoded control bundle and the ALU op-class encodings.
package mips_pipe_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       beq;
    logic       bne;
    logic       bgtz;
  } ctrl_t;

endpackage

// File: rtl/control_pipe_if.sv
// Decode-side bundle in, per-stage controls and front-end steering out.
// The decoder/datapath side uses master; control_pipe uses slave.
interface control_pipe_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic                  id_reg_dst;
  logic                  id_alu_src;
  logic                  id_mem_to_reg;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_mem_write;
  logic [1:0]            id_alu_op;
  logic                  id_beq;
  logic                  id_bne;
  logic                  id_bgtz;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  ex_zero;
  logic                  ex_neg;

  logic                  ex_alu_src;
  logic [1:0]            ex_alu_op;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic                  mem_mem_read;
  logic                  mem_mem_write;
  logic                  wb_reg_write;
  logic                  wb_mem_to_reg;
  logic [REG_ADDR_W-1:0] wb_dest;
  logic                  pc_write;
  logic                  ifid_write;
  logic                  ifid_flush;
  logic                  pc_src;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read,
           id_mem_write, id_alu_op, id_beq, id_bne, id_bgtz, id_rs, id_rt, id_rd,
           ex_zero, ex_neg,
    input  ex_alu_src, ex_alu_op, ex_rt, mem_mem_read, mem_mem_write,
           wb_reg_write, wb_mem_to_reg, wb_dest, pc_write, ifid_write,
           ifid_flush, pc_src, stall_count
  );

  modport slave (
    input  id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read,
           id_mem_write, id_alu_op, id_beq, id_bne, id_bgtz, id_rs, id_rt, id_rd,
           ex_zero, ex_neg,
    output ex_alu_src, ex_alu_op, ex_rt, mem_mem_read, mem_mem_write,
           wb_reg_write, wb_mem_to_reg, wb_dest, pc_write, ifid_write,
           ifid_flush, pc_src, stall_count
  );
endinterface

// File: rtl/hazard_detect.sv
// Branch resolution and load-use detection for the instruction in EX.
// A taken branch outranks a load-use stall: the stalled ID slot is squashed anyway.
module hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_ex_mem_read,
  input  logic                  i_ex_beq,
  input  logic                  i_ex_bne,
  input  logic                  i_ex_bgtz,
  input  logic                  i_ex_zero,
  input  logic                  i_ex_neg,
  input  logic [REG_ADDR_W-1:0] i_ex_dest,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  output logic                  o_pc_write,
  output logic                  o_ifid_write,
  output logic                  o_ifid_flush,
  output logic                  o_pc_src,
  output logic                  o_bubble,
  output logic                  o_stall
);
  logic w_taken;
  logic w_hazard;

  // taken/hazard decode and front-end steering with flush priority
  always_comb begin
    w_taken      = (i_ex_beq & i_ex_zero) | (i_ex_bne & ~i_ex_zero) |
                   (i_ex_bgtz & ~i_ex_zero & ~i_ex_neg);
    w_hazard     = i_ex_mem_read & (i_ex_dest != {REG_ADDR_W{1'b0}}) &
                   ((i_ex_dest == i_id_rs) | (i_ex_dest == i_id_rt));
    o_pc_src     = w_taken;
    o_ifid_flush = w_taken;
    o_pc_write   = 1'b1;
    o_ifid_write = 1'b1;
    o_bubble     = 1'b0;
    o_stall      = 1'b0;
    if (w_taken) begin
      o_bubble = 1'b1;
    end else if (w_hazard) begin
      o_pc_write   = 1'b0;
      o_ifid_write = 1'b0;
      o_bubble     = 1'b1;
      o_stall      = 1'b1;
    end else begin
      o_bubble = 1'b0;
    end
  end
endmodule

// File: rtl/control_pipe.sv
// ID/EX, EX/MEM and MEM/WB control registers plus stall accounting.
// Stages never hold; stalls and flushes are realised as bubbles into ID/EX.
module control_pipe
  import mips_pipe_pkg::ctrl_t;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  control_pipe_if.slave bus
);
  ctrl_t                 w_id_ctrl;
  ctrl_t                 w_idex_next;
  ctrl_t                 r_idex_ctrl;
  logic [REG_ADDR_W-1:0] w_idex_rt_next;
  logic [REG_ADDR_W-1:0] w_idex_rd_next;
  logic [REG_ADDR_W-1:0] r_idex_rt;
  logic [REG_ADDR_W-1:0] r_idex_rd;
  logic [REG_ADDR_W-1:0] w_ex_dest;

  logic                  r_exmem_reg_write;
  logic                  r_exmem_mem_to_reg;
  logic                  r_exmem_mem_read;
  logic                  r_exmem_mem_write;
  logic [REG_ADDR_W-1:0] r_exmem_dest;

  logic                  r_memwb_reg_write;
  logic                  r_memwb_mem_to_reg;
  logic [REG_ADDR_W-1:0] r_memwb_dest;

  logic [CNT_W-1:0]      r_stall_count;

  logic w_pc_write, w_ifid_write, w_ifid_flush, w_pc_src, w_bubble, w_stall;

  assign w_id_ctrl = '{reg_dst:    bus.id_reg_dst,
                       alu_src:    bus.id_alu_src,
                       mem_to_reg: bus.id_mem_to_reg,
                       reg_write:  bus.id_reg_write,
                       mem_read:   bus.id_mem_read,
                       mem_write:  bus.id_mem_write,
                       alu_op:     bus.id_alu_op,
                       beq:        bus.id_beq,
                       bne:        bus.id_bne,
                       bgtz:       bus.id_bgtz};

  assign w_ex_dest = r_idex_ctrl.reg_dst ? r_idex_rd : r_idex_rt;

  // a bubble is a full nop, register fields included, so it never aliases a real dest
  always_comb begin
    w_idex_next    = w_id_ctrl;
    w_idex_rt_next = bus.id_rt;
    w_idex_rd_next = bus.id_rd;
    if (w_bubble) begin
      w_idex_next    = '0;
      w_idex_rt_next = {REG_ADDR_W{1'b0}};
      w_idex_rd_next = {REG_ADDR_W{1'b0}};
    end else begin
      w_idex_next    = w_id_ctrl;
    end
  end

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
    .i_ex_mem_read (r_idex_ctrl.mem_read),
    .i_ex_beq      (r_idex_ctrl.beq),
    .i_ex_bne      (r_idex_ctrl.bne),
    .i_ex_bgtz     (r_idex_ctrl.bgtz),
    .i_ex_zero     (bus.ex_zero),
    .i_ex_neg      (bus.ex_neg),
    .i_ex_dest     (w_ex_dest),
    .i_id_rs       (bus.id_rs),
    .i_id_rt       (bus.id_rt),
    .o_pc_write    (w_pc_write),
    .o_ifid_write  (w_ifid_write),
    .o_ifid_flush  (w_ifid_flush),
    .o_pc_src      (w_pc_src),
    .o_bubble      (w_bubble),
    .o_stall       (w_stall)
  );

  // pipeline stage registers and stall counter; writes to $0 are dropped entering MEM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idex_ctrl        <= '0;
      r_idex_rt          <= {REG_ADDR_W{1'b0}};
      r_idex_rd          <= {REG_ADDR_W{1'b0}};
      r_exmem_reg_write  <= 1'b0;
      r_exmem_mem_to_reg <= 1'b0;
      r_exmem_mem_read   <= 1'b0;
      r_exmem_mem_write  <= 1'b0;
      r_exmem_dest       <= {REG_ADDR_W{1'b0}};
      r_memwb_reg_write  <= 1'b0;
      r_memwb_mem_to_reg <= 1'b0;
      r_memwb_dest       <= {REG_ADDR_W{1'b0}};
      r_stall_count      <= {CNT_W{1'b0}};
    end else begin
      r_idex_ctrl        <= w_idex_next;
      r_idex_rt          <= w_idex_rt_next;
      r_idex_rd          <= w_idex_rd_next;
      r_exmem_reg_write  <= r_idex_ctrl.reg_write & (w_ex_dest != {REG_ADDR_W{1'b0}});
      r_exmem_mem_to_reg <= r_idex_ctrl.mem_to_reg;
      r_exmem_mem_read   <= r_idex_ctrl.mem_read;
      r_exmem_mem_write  <= r_idex_ctrl.mem_write;
      r_exmem_dest       <= w_ex_dest;
      r_memwb_reg_write  <= r_exmem_reg_write;
      r_memwb_mem_to_reg <= r_exmem_mem_to_reg;
      r_memwb_dest       <= r_exmem_dest;
      if (w_stall) begin
        r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_stall_count <= r_stall_count;
      end
    end
  end

  assign bus.ex_alu_src    = r_idex_ctrl.alu_src;
  assign bus.ex_alu_op     = r_idex_ctrl.alu_op;
  assign bus.ex_rt         = r_idex_rt;
  assign bus.mem_mem_read  = r_exmem_mem_read;
  assign bus.mem_mem_write = r_exmem_mem_write;
  assign bus.wb_reg_write  = r_memwb_reg_write;
  assign bus.wb_mem_to_reg = r_memwb_mem_to_reg;
  assign bus.wb_dest       = r_memwb_dest;
  assign bus.pc_write      = w_pc_write;
  assign bus.ifid_write    = w_ifid_write;
  assign bus.ifid_flush    = w_ifid_flush;
  assign bus.pc_src        = w_pc_src;
  assign bus.stall_count   = r_stall_count;
endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: a directed cycle table for the named scenarios, then
// random instruction streams, all checked against an instruction-level pipeline model.
module tb_control_pipe;
  import mips_pipe_pkg::*;

  localparam int RW = 5;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  control_pipe_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();
  control_pipe #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write;
    logic [1:0] alu_op;
    logic beq, bne, bgtz;
    logic [4:0] rs, rt, rd;
  } instr_t;

  typedef struct {
    instr_t ins;
    logic z, n, r;
    logic pcw, ifw, pcs, fl, alusrc;
    logic [1:0] aluop;
    logic [4:0] exrt;
    logic memrd, wbrw;
    logic [4:0] wbdest;
    int unsigned stalls;
  } vec_t;

  // model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB, holding whole instructions
  instr_t      m_pipe [3];
  int unsigned m_stalls;
  instr_t      cur_ins;
  logic        cur_z, cur_n, cur_r;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  vec_t        tab [$];

  function automatic instr_t mk_r(input logic [4:0] rs, rt, rd);
    instr_t i = '0;
    i.reg_dst = 1'b1; i.reg_write = 1'b1; i.alu_op = ALUOP_R;
    i.rs = rs; i.rt = rt; i.rd = rd;
    return i;
  endfunction

  function automatic instr_t mk_lw(input logic [4:0] rs, rt);
    instr_t i = '0;
    i.alu_src = 1'b1; i.mem_read = 1'b1; i.mem_to_reg = 1'b1; i.reg_write = 1'b1;
    i.alu_op = ALUOP_MEM; i.rs = rs; i.rt = rt;
    return i;
  endfunction

  function automatic instr_t mk_sw(input logic [4:0] rs, rt);
    instr_t i = '0;
    i.alu_src = 1'b1; i.mem_write = 1'b1; i.alu_op = ALUOP_MEM; i.rs = rs; i.rt = rt;
    return i;
  endfunction

  function automatic instr_t mk_br(input int kind, input logic [4:0] rs, rt);
    instr_t i = '0;
    i.alu_op = ALUOP_BR; i.rs = rs; i.rt = rt;
    i.beq = (kind == 0); i.bne = (kind == 1); i.bgtz = (kind == 2);
    return i;
  endfunction

  function automatic logic [4:0] dest_of(input instr_t i);
    return i.reg_dst ? i.rd : i.rt;
  endfunction

  function automatic logic taken_of(input instr_t i, input logic z, input logic n);
    if (i.beq && z) return 1'b1;
    if (i.bne && !z) return 1'b1;
    if (i.bgtz && !z && !n) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic hazard_of(input instr_t ex, input instr_t id);
    logic [4:0] d = dest_of(ex);
    return ex.mem_read && d != 5'd0 && (d == id.rs || d == id.rt);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic apply(input instr_t i, input logic z, input logic n, input logic r);
    cur_ins = i; cur_z = z; cur_n = n; cur_r = r;
    bus.id_reg_dst = i.reg_dst;   bus.id_alu_src = i.alu_src;
    bus.id_mem_to_reg = i.mem_to_reg; bus.id_reg_write = i.reg_write;
    bus.id_mem_read = i.mem_read; bus.id_mem_write = i.mem_write;
    bus.id_alu_op = i.alu_op;     bus.id_beq = i.beq;
    bus.id_bne = i.bne;           bus.id_bgtz = i.bgtz;
    bus.id_rs = i.rs; bus.id_rt = i.rt; bus.id_rd = i.rd;
    bus.ex_zero = z; bus.ex_neg = n;
    rst_n = r;
    #2;
  endtask

  task automatic check_model();
    logic tk, hz, stall;
    tk = taken_of(m_pipe[0], cur_z, cur_n);
    hz = hazard_of(m_pipe[0], cur_ins);
    stall = hz && !tk;
    chk("m_pc_write", {31'd0, bus.pc_write}, {31'd0, !stall});
    chk("m_ifid_write", {31'd0, bus.ifid_write}, {31'd0, !stall});
    chk("m_pc_src", {31'd0, bus.pc_src}, {31'd0, tk});
    chk("m_ifid_flush", {31'd0, bus.ifid_flush}, {31'd0, tk});
    chk("m_ex_alu_src", {31'd0, bus.ex_alu_src}, {31'd0, m_pipe[0].alu_src});
    chk("m_ex_alu_op", {30'd0, bus.ex_alu_op}, {30'd0, m_pipe[0].alu_op});
    chk("m_ex_rt", {27'd0, bus.ex_rt}, {27'd0, m_pipe[0].rt});
    chk("m_mem_read", {31'd0, bus.mem_mem_read}, {31'd0, m_pipe[1].mem_read});
    chk("m_mem_write", {31'd0, bus.mem_mem_write}, {31'd0, m_pipe[1].mem_write});
    chk("m_wb_reg_write", {31'd0, bus.wb_reg_write},
        {31'd0, m_pipe[2].reg_write && dest_of(m_pipe[2]) != 5'd0});
    chk("m_wb_mem_to_reg", {31'd0, bus.wb_mem_to_reg}, {31'd0, m_pipe[2].mem_to_reg});
    chk("m_wb_dest", {27'd0, bus.wb_dest}, {27'd0, dest_of(m_pipe[2])});
    chk("m_stall_count", bus.stall_count, m_stalls);
  endtask

  task automatic finish_cycle();
    logic tk, hz;
    @(posedge clk);
    tk = taken_of(m_pipe[0], cur_z, cur_n);
    hz = hazard_of(m_pipe[0], cur_ins);
    if (!cur_r) begin
      m_pipe = '{default: '0};
      m_stalls = 0;
    end else begin
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = (tk || hz) ? instr_t'('0) : cur_ins;
      if (hz && !tk) m_stalls++;
    end
    cyc++;
    #1;
  endtask

  task automatic add_vec(input instr_t i, input logic z, n, r, pcw, ifw, pcs, fl, alusrc,
                         input logic [1:0] aluop, input logic [4:0] exrt,
                         input logic memrd, wbrw, input logic [4:0] wbdest,
                         input int unsigned stalls);
    vec_t v;
    v.ins = i; v.z = z; v.n = n; v.r = r; v.pcw = pcw; v.ifw = ifw; v.pcs = pcs; v.fl = fl;
    v.alusrc = alusrc; v.aluop = aluop; v.exrt = exrt; v.memrd = memrd; v.wbrw = wbrw;
    v.wbdest = wbdest; v.stalls = stalls;
    tab.push_back(v);
  endtask

  initial begin
    instr_t nop, weird, ri;
    logic [31:0] rb;
    nop = '0;
    weird = mk_br(1, 5'd0, 5'd8);
    weird.mem_read = 1'b1;

    //      ins              z     n     r     pcw   ifw   pcs   fl    asrc  aluop  exrt   mrd   wbrw  wbdst stalls
    add_vec(mk_r(1,2,9),     1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0,  1'b0, 1'b0, 5'd0,  0);
    add_vec(nop,             1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 5'd2,  1'b0, 1'b0, 5'd0,  0);
    add_vec(nop,             1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0,  1'b0, 1'b0, 5'd0,  0);
    add_vec(mk_lw(3,8),      1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0,  1'b0, 1'b1, 5'd9,  0);
    add_vec(mk_r(8,4,10),    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd8,  1'b0, 1'b0, 5'd0,  0);
    add_vec(mk_r(8,4,10),    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0,  1'b1, 1'b0, 5'd0,  1);
    add_vec(nop,             1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 5'd4,  1'b0, 1'b1, 5'd8,  1);
    add_vec(mk_br(0,1,2),    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0,  1'b0, 1'b0, 5'd0,  1);
    add_vec(mk_r(1,2,11),    1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 5'd2,  1'b0, 1'b1, 5'd10, 1);
    add_vec(mk_br(0,1,2),    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0,  1'b0, 1'b0, 5'd0,  1);
    add_vec(mk_br(2,5,0),    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 5'd2,  1'b0, 1'b0, 5'd2,  1);
    add_vec(nop,             1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 5'd0,  1'b0, 1'b0, 5'd0,  1);
    add_vec(mk_br(2,5,0),    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0,  1'b0, 1'b0, 5'd2,  1);
    add_vec(nop,             1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 5'd0,  1'b0, 1'b0, 5'd0,  1);
    add_vec(weird,           1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0,  1'b0, 1'b0, 5'd0,  1);
    add_vec(mk_r(8,4,10),    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 5'd8,  1'b0, 1'b0, 5'd0,  1);
    add_vec(mk_r(1,2,0),     1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0,  1'b1, 1'b0, 5'd0,  1);
    add_vec(nop,             1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 5'd2,  1'b0, 1'b0, 5'd8,  1);
    add_vec(mk_lw(3,8),      1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0,  1'b0, 1'b0, 5'd0,  1);
    add_vec(nop,             1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 5'd8,  1'b0, 1'b0, 5'd0,  1);
    add_vec(nop,             1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0,  1'b1, 1'b0, 5'd0,  1);
    add_vec(nop,             1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0,  1'b0, 1'b0, 5'd0,  0);
    add_vec(nop,             1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0,  1'b0, 1'b0, 5'd0,  0);

    // power-up reset: DUT state is unknown until two reset edges have passed
    apply(nop, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    m_pipe = '{default: '0};
    m_stalls = 0;
    #1;

    foreach (tab[k]) begin
      apply(tab[k].ins, tab[k].z, tab[k].n, tab[k].r);
      chk("t_pc_write", {31'd0, bus.pc_write}, {31'd0, tab[k].pcw});
      chk("t_ifid_write", {31'd0, bus.ifid_write}, {31'd0, tab[k].ifw});
      chk("t_pc_src", {31'd0, bus.pc_src}, {31'd0, tab[k].pcs});
      chk("t_ifid_flush", {31'd0, bus.ifid_flush}, {31'd0, tab[k].fl});
      chk("t_ex_alu_src", {31'd0, bus.ex_alu_src}, {31'd0, tab[k].alusrc});
      chk("t_ex_alu_op", {30'd0, bus.ex_alu_op}, {30'd0, tab[k].aluop});
      chk("t_ex_rt", {27'd0, bus.ex_rt}, {27'd0, tab[k].exrt});
      chk("t_mem_read", {31'd0, bus.mem_mem_read}, {31'd0, tab[k].memrd});
      chk("t_wb_reg_write", {31'd0, bus.wb_reg_write}, {31'd0, tab[k].wbrw});
      chk("t_wb_dest", {27'd0, bus.wb_dest}, {27'd0, tab[k].wbdest});
      chk("t_stall_count", bus.stall_count, tab[k].stalls);
      check_model();
      finish_cycle();
    end

    // random streams over a small register space so load-use and branch overlaps are frequent
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 6))
        0: ri = mk_r(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        1, 2: ri = mk_lw(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        3: ri = mk_sw(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        4: ri = mk_br($urandom_range(0, 2), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        5: ri = '0;
        default: begin
          rb = $urandom;
          ri = rb[24:0];
          ri.rs = ri.rs & 5'd3; ri.rt = ri.rt & 5'd3; ri.rd = ri.rd & 5'd3;
        end
      endcase
      apply(ri, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 49) != 0));
      check_model();
      finish_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
